// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM states, master
// indices, the default timeout and the address-decoder select type.
package bus_arbiter_pkg;

  // Decode of bus_addr produced by the external address decoder.
  typedef enum logic [2:0] {
    SELECT_NONE   = 3'd0,
    SELECT_RAM    = 3'd1,
    SELECT_ROM    = 3'd2,
    SELECT_IO     = 3'd3,
    SELECT_PERIPH = 3'd4
  } device_select_t;

  // Arbiter transaction FSM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Master indices: 0 is the CPU data port, 1 is the video/DMA port.
  localparam logic MASTER_CPU   = 1'b0;
  localparam logic MASTER_VIDEO = 1'b1;

  // Cycles without bus_ready before a transaction is aborted with error.
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side request/response and shared-bus signals of the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic [1:0]        m_req;
  logic [1:0]        m_we;
  logic [1:0][31:0]  m_addr;
  logic [1:0][31:0]  m_wdata;
  logic [1:0][3:0]   m_wstrb;
  logic [1:0]        m_gnt;
  logic [1:0]        m_done;
  logic              m_err;
  logic [31:0]       m_rdata;

  logic              bus_valid;
  logic              bus_we;
  logic [31:0]       bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_wstrb;
  logic              bus_ready;
  logic [31:0]       bus_rdata;
  device_select_t    device_select;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, m_wstrb,
    input  bus_ready, bus_rdata, device_select,
    output m_gnt, m_done, m_err, m_rdata,
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, m_wstrb,
    output bus_ready, bus_rdata, device_select,
    input  m_gnt, m_done, m_err, m_rdata,
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Two-way round-robin picker: a lone requester always wins; on a tie the
// master that was not granted last wins. Purely combinational.
module rr_picker (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Select one-hot winner from the request pair and the last-grant pointer.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b00:   gnt = 2'b00;
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (last == 1'b1) begin
          gnt = 2'b01;
        end else begin
          gnt = 2'b10;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master shared-bus arbiter. One transaction at a time: IDLE picks an
// owner and latches its fields, BUSY drives the bus until ready, unmapped
// decode or timeout, RESP returns a one-cycle done pulse to the owner.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_arbiter_if.slave  bif
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t        state_r;
  logic              owner_r;
  logic              last_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              we_r;
  logic [31:0]       addr_r;
  logic [31:0]       wdata_r;
  logic [3:0]        wstrb_r;
  logic [1:0]        gnt_r;
  logic              valid_r;
  logic [1:0]        done_r;
  logic              err_r;
  logic [31:0]       rdata_r;

  logic [1:0]        pick_s;
  logic              pick_idx_s;

  rr_picker u_rr_picker (
    .req  (bif.m_req),
    .last (last_r),
    .gnt  (pick_s)
  );

  assign pick_idx_s = pick_s[1];

  assign bif.m_gnt     = gnt_r;
  assign bif.m_done    = done_r;
  assign bif.m_err     = err_r;
  assign bif.m_rdata   = rdata_r;
  assign bif.bus_valid = valid_r;
  assign bif.bus_we    = we_r;
  assign bif.bus_addr  = addr_r;
  assign bif.bus_wdata = wdata_r;
  assign bif.bus_wstrb = wstrb_r;

  // Transaction FSM with registered grant, bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      owner_r <= MASTER_CPU;
      last_r  <= MASTER_VIDEO;
      cnt_r   <= '0;
      we_r    <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      wstrb_r <= 4'b0000;
      gnt_r   <= 2'b00;
      valid_r <= 1'b0;
      done_r  <= 2'b00;
      err_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (|bif.m_req) begin
            owner_r <= pick_idx_s;
            we_r    <= bif.m_we[pick_idx_s];
            addr_r  <= bif.m_addr[pick_idx_s];
            wdata_r <= bif.m_wdata[pick_idx_s];
            wstrb_r <= bif.m_wstrb[pick_idx_s];
            gnt_r   <= pick_s;
            valid_r <= 1'b1;
            cnt_r   <= '0;
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          // Unmapped decode aborts at once; otherwise wait for ready or timeout.
          if (bif.device_select == SELECT_NONE) begin
            valid_r <= 1'b0;
            done_r  <= gnt_r;
            err_r   <= 1'b1;
            rdata_r <= 32'h0000_0000;
            state_r <= RESP;
          end else if (bif.bus_ready) begin
            valid_r <= 1'b0;
            done_r  <= gnt_r;
            err_r   <= 1'b0;
            rdata_r <= we_r ? 32'h0000_0000 : bif.bus_rdata;
            state_r <= RESP;
          end else if (cnt_r == CNT_LAST) begin
            valid_r <= 1'b0;
            done_r  <= gnt_r;
            err_r   <= 1'b1;
            rdata_r <= 32'h0000_0000;
            state_r <= RESP;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            state_r <= BUSY;
          end
        end
        RESP: begin
          done_r  <= 2'b00;
          err_r   <= 1'b0;
          rdata_r <= 32'h0000_0000;
          gnt_r   <= 2'b00;
          last_r  <= owner_r;
          cnt_r   <= '0;
          state_r <= IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          done_r  <= 2'b00;
          err_r   <= 1'b0;
          rdata_r <= 32'h0000_0000;
          gnt_r   <= 2'b00;
          cnt_r   <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: stimulus pushes the expected response into
// a scoreboard queue, a negedge monitor pops and compares on every m_done.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  typedef struct packed {
    logic [1:0]  gnt;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  localparam int T_CYC = TIMEOUT_CYCLES_DEFAULT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        auto_ready = 1'b0;
  logic [31:0] slave_rdata = 32'h0;
  int          total = 0;
  int          bad = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;

  bus_arbiter_if bif();

  bus_arbiter #(.TIMEOUT_CYCLES(T_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif)
  );

  always #5 clk = ~clk;

  // Slave model: accepts in the first BUSY cycle when auto_ready is set.
  always_comb bif.bus_ready = auto_ready & bif.bus_valid;
  always_comb bif.bus_rdata = slave_rdata;

  // Address decoder model: top nibble selects the device, 0xF is unmapped.
  always_comb begin
    bif.device_select = SELECT_ROM;
    case (bif.bus_addr[31:28])
      4'h0:    bif.device_select = SELECT_RAM;
      4'hC:    bif.device_select = SELECT_IO;
      4'hE:    bif.device_select = SELECT_PERIPH;
      4'hF:    bif.device_select = SELECT_NONE;
      default: bif.device_select = SELECT_ROM;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compare each done pulse, and quiet outputs otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.m_done != 2'b00) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", {30'd0, bif.m_done}, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("done_owner", {30'd0, bif.m_done}, {30'd0, mon_e.gnt});
          check("done_err", {31'd0, bif.m_err}, {31'd0, mon_e.err});
          check("done_rdata", bif.m_rdata, mon_e.rdata);
        end
      end else begin
        check("quiet_err", {31'd0, bif.m_err}, 32'd0);
        check("quiet_rdata", bif.m_rdata, 32'd0);
      end
    end
  end

  task automatic run_txn(input int idx, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic ready, input logic [31:0] rd,
                         input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
    exp_t       e;
    logic [1:0] oh;
    int         n;
    logic       stable;
    oh = (idx == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    auto_ready = ready;
    slave_rdata = rd;
    bif.m_we[idx] = we;
    bif.m_addr[idx] = addr;
    bif.m_wdata[idx] = wdata;
    bif.m_wstrb[idx] = wstrb;
    bif.m_req[idx] = 1'b1;
    e.gnt = oh;
    e.err = exp_err;
    e.rdata = exp_rd;
    sb_q.push_back(e);
    @(negedge clk);
    // Drop and scramble the request; the latched transaction must not notice.
    bif.m_req = 2'b00;
    bif.m_we[idx] = ~we;
    bif.m_addr[idx] = ~addr;
    bif.m_wdata[idx] = ~wdata;
    bif.m_wstrb[idx] = ~wstrb;
    check("busy_gnt", {30'd0, bif.m_gnt}, {30'd0, oh});
    check("busy_valid", {31'd0, bif.bus_valid}, 32'd1);
    check("busy_addr", bif.bus_addr, addr);
    check("busy_we", {31'd0, bif.bus_we}, {31'd0, we});
    check("busy_wdata", bif.bus_wdata, wdata);
    check("busy_wstrb", {28'd0, bif.bus_wstrb}, {28'd0, wstrb});
    n = 1;
    stable = 1'b1;
    while (bif.m_done == 2'b00 && n < 400) begin
      if (!(bif.bus_valid && bif.bus_addr == addr && bif.bus_we == we &&
            bif.bus_wdata == wdata && bif.m_gnt == oh)) stable = 1'b0;
      @(negedge clk);
      n++;
    end
    check("done_latency", n, exp_lat);
    check("bus_stable", {31'd0, stable}, 32'd1);
    check("resp_valid_low", {31'd0, bif.bus_valid}, 32'd0);
    @(negedge clk);
    check("idle_gnt", {30'd0, bif.m_gnt}, 32'd0);
    check("idle_done", {30'd0, bif.m_done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rr_exp [4];
    logic [1:0] prev;
    exp_t       e;
    int         ng;
    int         cyc;
    int         last_cyc;
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

    bif.m_req = 2'b00;
    bif.m_we = 2'b00;
    bif.m_addr = '0;
    bif.m_wdata = '0;
    bif.m_wstrb = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_gnt", {30'd0, bif.m_gnt}, 32'd0);
    check("rst_valid", {31'd0, bif.bus_valid}, 32'd0);
    check("rst_done", {30'd0, bif.m_done}, 32'd0);
    check("rst_err", {31'd0, bif.m_err}, 32'd0);
    check("rst_rdata", bif.m_rdata, 32'd0);
    check("rst_addr", bif.bus_addr, 32'd0);
    rst_n = 1'b1;

    // Contention from reset: m0 wins first tie, then strict alternation.
    @(negedge clk);
    auto_ready = 1'b1;
    slave_rdata = 32'h1234_5678;
    bif.m_addr[0] = 32'h0000_0020;
    bif.m_addr[1] = 32'h0000_0030;
    for (int i = 0; i < 4; i++) begin
      e.gnt = rr_exp[i];
      e.err = 1'b0;
      e.rdata = 32'h1234_5678;
      sb_q.push_back(e);
    end
    bif.m_req = 2'b11;
    prev = 2'b00;
    ng = 0;
    cyc = 0;
    last_cyc = 0;
    while (ng < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bif.m_gnt != 2'b00 && prev == 2'b00) begin
        check("rr_gnt", {30'd0, bif.m_gnt}, {30'd0, rr_exp[ng]});
        if (ng > 0) check("rr_spacing", cyc - last_cyc, 3);
        last_cyc = cyc;
        ng++;
        if (ng == 4) bif.m_req = 2'b00;
      end
      prev = bif.m_gnt;
    end
    check("rr_count", ng, 4);
    repeat (3) @(negedge clk);

    // Single read with immediate ready.
    run_txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF,
            2, 1'b0, 32'hDEAD_BEEF);
    // Unmapped read: no wait on bus_ready, error with zero data.
    run_txn(1, 1'b0, 32'hF000_0000, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D,
            2, 1'b1, 32'h0);
    // Write with byte strobe: bus fields exact, rdata forced to zero.
    run_txn(1, 1'b1, 32'hE000_0100, 32'h00AB_0000, 4'b0100, 1'b1, 32'h5555_5555,
            2, 1'b0, 32'h0);
    // Timeout: exactly T_CYC BUSY cycles, then error.
    run_txn(0, 1'b1, 32'hC000_0004, 32'h1111_2222, 4'b1111, 1'b0, 32'h7777_7777,
            T_CYC + 1, 1'b1, 32'h0);

    // Reset asserted mid-BUSY: outputs drop without waiting for a clock edge.
    @(negedge clk);
    auto_ready = 1'b0;
    bif.m_we[0] = 1'b0;
    bif.m_addr[0] = 32'h0000_0040;
    bif.m_req[0] = 1'b1;
    @(negedge clk);
    bif.m_req = 2'b00;
    repeat (5) @(negedge clk);
    check("pre_rst_valid", {31'd0, bif.bus_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", {31'd0, bif.bus_valid}, 32'd0);
    check("async_gnt", {30'd0, bif.m_gnt}, 32'd0);
    check("async_addr", bif.bus_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Served normally after reset release.
    run_txn(0, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 1'b1, 32'h0BAD_F00D,
            2, 1'b0, 32'h0BAD_F00D);

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
